// File: rtl/aes_pkg.sv
// Shared AES-256 types and constants: block widths, controller FSM states,
// and the byte-level S-box and MixColumns helpers.
package aes_pkg;

  localparam int NR      = 14;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [KEY_W-1:0]   key_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / block-out handshakes plus the round-key lookup to the key store.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       inValid;
  logic       inReady;
  block_t     inData;
  logic [3:0] roundIdx;
  key_t       roundKey;
  logic       outValid;
  logic       outReady;
  block_t     outData;
  logic       busy;

  modport master (
    output inValid, inData, roundKey, outReady,
    input  inReady, roundIdx, outValid, outData, busy
  );

  modport slave (
    input  inValid, inData, roundKey, outReady,
    output inReady, roundIdx, outValid, outData, busy
  );
endinterface

// File: rtl/AesRoundFun.sv
// One combinational AES encryption round; lastRound drops MixColumns.
module AesRoundFun
  import aes_pkg::*;
(
  input  block_t state,
  input  key_t   roundKey,
  input  logic   lastRound,
  output block_t result
);
  block_t sb;
  block_t sr;
  block_t mc;

  SubBytes u_sub_bytes (
    .din  (state),
    .dout (sb)
  );

  // Byte k = row (k % 4), column (k / 4); row r rotates left by r columns.
  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end
  end

  assign result = (lastRound ? sr : mc) ^ roundKey;
endmodule

// File: rtl/SubBytes.sv
// Sixteen parallel forward S-boxes; byte order is irrelevant here.
module SubBytes
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-256 encryption controller: one round per cycle, round keys
// fetched combinationally by index from an external key store.
module aes_round_ctrl #(
  parameter int NR = aes_pkg::NR
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RND  = 4'(NR - 1);
  localparam logic [3:0] FINAL_IDX = 4'(NR);

  state_e     fsm_q, fsm_d;
  logic [3:0] rnd_q;
  block_t     state_reg;
  block_t     round_out;

  AesRoundFun u_round_fun (
    .state     (state_reg),
    .roundKey  (bus.roundKey),
    .lastRound (fsm_q == FINAL),
    .result    (round_out)
  );

  always_comb begin
    fsm_d        = fsm_q;
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.roundIdx = 4'd0;
    unique case (fsm_q)
      IDLE: begin
        bus.inReady = 1'b1;
        if (bus.inValid) fsm_d = ROUND;
      end
      ROUND: begin
        bus.roundIdx = rnd_q;
        if (rnd_q == LAST_RND) fsm_d = FINAL;
      end
      FINAL: begin
        bus.roundIdx = FINAL_IDX;
        fsm_d        = DONE;
      end
      DONE: begin
        bus.outValid = 1'b1;
        if (bus.outReady) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.busy    = (fsm_q != IDLE);
  // Hide intermediate round state from the output bus.
  assign bus.outData = (fsm_q == DONE) ? state_reg : '0;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      fsm_q     <= IDLE;
      rnd_q     <= 4'd0;
      // NOTE: the datapath register is reset too, so a discarded block leaves no residue.
      state_reg <= '0;
    end else begin
      fsm_q <= fsm_d;
      unique case (fsm_q)
        IDLE: begin
          if (bus.inValid) begin
            state_reg <= bus.inData ^ bus.roundKey;
            rnd_q     <= 4'd1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          rnd_q     <= rnd_q + 4'd1;
        end
        FINAL: state_reg <= round_out;
        DONE: begin
          if (bus.outReady) rnd_q <= 4'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: FIPS-197 AES-256 key store and an arithmetic
// AES reference model; table vectors, random blocks and reset corner cases.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam block_t       FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t       FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    block_t pt;
    block_t ct;
    int     stall;
    bit     noisy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sb_tab [256];
  block_t     rk [16];

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Key store: round key selected purely by the index the controller asks for.
  assign bus.roundKey = rk[bus.roundIdx];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
  endfunction

  // S-box from the GF(2^8) inverse plus affine map; keys by FIPS-197 expansion.
  task automatic build_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  inv;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk[15] = '0;
  endtask

  function automatic block_t aes_ref(input block_t pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    block_t     res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[0][127-8*k -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb_tab[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++)
            t[w] = gmul(8'h02, s[w+4*c]) ^ gmul(8'h03, s[(w+1)%4+4*c]) ^
                   s[(w+2)%4+4*c] ^ s[(w+3)%4+4*c];
          for (int w = 0; w < 4; w++) s[w+4*c] = t[w];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Starts in IDLE one tick after an edge; returns the same way.
  task automatic run_block(input string tag, input block_t pt, input block_t ct,
                           input int stall, input bit noisy);
    check({tag, " idle ready"}, bus.inReady, 1);
    check({tag, " idle idx"}, bus.roundIdx, 0);
    bus.inValid  = 1'b1;
    bus.inData   = pt;
    bus.outReady = 1'b0;
    step();
    bus.inValid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s idx@%0d", tag, k + 1), bus.roundIdx, k + 1);
      check($sformatf("%s busy/rdy/vld@%0d", tag, k + 1),
            {bus.busy, bus.inReady, bus.outValid}, 3'b100);
      if (noisy) begin
        bus.inValid  = 1'($urandom_range(0, 1));
        bus.inData   = {$urandom, $urandom, $urandom, $urandom};
        bus.outReady = 1'($urandom_range(0, 1));
      end
      step();
    end
    check({tag, " valid"}, bus.outValid, 1);
    check({tag, " data"}, bus.outData, ct);
    for (int s = 0; s < stall; s++) begin
      bus.outReady = 1'b0;
      if (noisy) bus.inValid = 1'($urandom_range(0, 1));
      step();
      check($sformatf("%s hold vld/rdy/busy@%0d", tag, s),
            {bus.outValid, bus.inReady, bus.busy}, 3'b101);
      check($sformatf("%s hold data@%0d", tag, s), bus.outData, ct);
    end
    bus.outReady = 1'b1;
    step();
    bus.outReady = 1'b0;
    bus.inValid  = 1'b0;
    check({tag, " released"}, {bus.outValid, bus.inReady, bus.busy, bus.roundIdx},
          {3'b010, 4'd0});
    check({tag, " cleared"}, bus.outData, 0);
  endtask

  task automatic back_to_back();
    block_t pts [3];
    int     acc_cyc [3];
    int     n_in  = 0;
    int     n_out = 0;
    int     cyc   = 0;
    bit     take;
    for (int i = 0; i < 3; i++) begin
      pts[i]     = {$urandom, $urandom, $urandom, $urandom};
      acc_cyc[i] = 0;
    end
    bus.inData   = pts[0];
    bus.inValid  = 1'b1;
    bus.outReady = 1'b1;
    while (n_out < 3 && cyc < 100) begin
      take = bus.inReady && (n_in < 3);
      if (take) acc_cyc[n_in] = cyc;
      if (bus.outValid) begin
        check($sformatf("b2b ct%0d", n_out), bus.outData, aes_ref(pts[n_out]));
        n_out++;
      end
      step();
      cyc++;
      if (take) begin
        n_in++;
        if (n_in < 3) bus.inData = pts[n_in];
        else bus.inValid = 1'b0;
      end
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    check("b2b outputs", n_out, 3);
    check("b2b gap 0-1", acc_cyc[1] - acc_cyc[0], 16);
    check("b2b gap 1-2", acc_cyc[2] - acc_cyc[1], 16);
  endtask

  vec_t vecs [5];
  int   seen;

  initial begin
    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.outReady = 1'b0;
    build_model(FIPS_KEY);

    vecs[0] = '{FIPS_PT, FIPS_CT, 0, 1'b0};
    vecs[1] = '{FIPS_PT, FIPS_CT, 20, 1'b0};
    vecs[2] = '{FIPS_PT, FIPS_CT, 2, 1'b1};
    vecs[3] = '{128'h0, aes_ref(128'h0), 1, 1'b0};
    vecs[4] = '{{128{1'b1}}, aes_ref({128{1'b1}}), 0, 1'b1};

    repeat (2) step();
    check("reset vld/rdy/busy", {bus.outValid, bus.inReady, bus.busy}, 3'b010);
    check("reset idx", bus.roundIdx, 0);
    check("reset data", bus.outData, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_block($sformatf("vec%0d", i), vecs[i].pt, vecs[i].ct, vecs[i].stall, vecs[i].noisy);

    for (int i = 0; i < 4; i++) begin
      block_t pt;
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rand%0d", i), pt, aes_ref(pt), int'($urandom_range(0, 3)), 1'b1);
    end

    back_to_back();

    // Reset in the middle of the rounds, with inValid and outReady also high.
    bus.inValid = 1'b1;
    bus.inData  = FIPS_PT;
    step();
    bus.inValid = 1'b0;
    for (int n = 0; n < 20 && bus.roundIdx != 4'd7; n++) step();
    check("midrst reached rnd7", bus.roundIdx, 7);
    rst          = 1'b1;
    bus.inValid  = 1'b1;
    bus.outReady = 1'b1;
    step();
    check("midrst state", {bus.outValid, bus.inReady, bus.busy, bus.roundIdx}, {3'b010, 4'd0});
    check("midrst data", bus.outData, 0);
    step();
    check("midrst priority", bus.busy, 0);
    rst          = 1'b0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.outValid || bus.busy) seen++;
    end
    check("midrst no output", seen, 0);
    run_block("after midrst", FIPS_PT, FIPS_CT, 0, 1'b0);

    // Reset while a finished block waits for the consumer.
    bus.inValid = 1'b1;
    bus.inData  = FIPS_PT;
    step();
    bus.inValid = 1'b0;
    repeat (NR) step();
    check("donerst pending", bus.outValid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("donerst dropped", {bus.outValid, bus.inReady, bus.busy}, 3'b010);
    check("donerst data", bus.outData, 0);
    run_block("after donerst", 128'h0, vecs[3].ct, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, 14, number of AES rounds; fixed at 14 for AES-256, and other values are unsupported.
REQ-002 Clocking and reset SHALL be one clock with a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inValid  in  1  input block offered.
REQ-006 inReady  out  1  controller can accept a block.
REQ-007 inData  in  128  plaintext block, byte 0 in [127:120].
REQ-008 roundIdx  out  4  index of the round key required this cycle, range 0..NR.
REQ-009 roundKey  in  128  round key for roundIdx, driven combinationally by the external key store in the same cycle.
REQ-010 outValid  out  1  ciphertext available.
REQ-011 outReady  in  1  consumer accepts the ciphertext.
REQ-012 outData  out  128  ciphertext block, same byte order as inData.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, FINAL and DONE.
REQ-015 IDLE: inReady=1 and roundIdx=0; on inValid&&inReady, stateReg <= inData ^ roundKey, rnd <= 1, go to ROUND.
REQ-016 ROUND: roundIdx=rnd; stateReg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(stateReg))), roundKey); rnd++.
REQ-017 ROUND SHALL transition to FINAL when the round just executed is NR-1 (rnd==13); otherwise it remains in ROUND.
REQ-018 FINAL: roundIdx=NR; stateReg <= AddRoundKey(ShiftRows(SubBytes(stateReg)), roundKey); go to DONE.
REQ-019 DONE: outValid=1 and outData=stateReg, both held stable until outReady=1; on outValid&&outReady, go to IDLE.
REQ-020 Latency: outValid SHALL rise exactly NR=14 cycles after the accepting edge, with 1 ROUND/FINAL step per cycle.
REQ-021 Back-to-back: the next block SHALL be accepted no earlier than the cycle after the DONE handshake, since IDLE is mandatory; throughput is 1 block per 16 cycles minimum.
REQ-022 inValid in any non-IDLE state SHALL be ignored, with inReady=0 and no state change.
REQ-023 outReady outside DONE SHALL be ignored.
REQ-024 rnd SHALL be 4 bits, SHALL never exceed NR, and SHALL be cleared to 0 on return to IDLE.
REQ-025 roundIdx SHALL be a pure function of the FSM state and rnd, with no dependence on inputs.
REQ-026 outData SHALL read 0 outside DONE, to prevent intermediate state leakage.
REQ-027 A single SubBytes datapath instance (16 S-boxes) SHALL be shared by the ROUND and FINAL steps.

Reset
REQ-028 rst=1 SHALL force state IDLE, rnd=0, stateReg=0, outValid=0, busy=0 and inReady=1 on the next edge.
REQ-029 rst in any state, including mid-ROUND and DONE with a pending output, SHALL discard the in-flight block with no outValid pulse.
REQ-030 rst has priority over simultaneous inValid or outReady.
REQ-031 After reset deassertion, a block SHALL be accepted on the first edge where inValid=1.

Structure
REQ-032 Shared package aes_pkg SHALL hold the FSM state typedef, NR, and the block and key width constants (128).
REQ-033 Sub-module AesRoundFun SHALL be purely combinational, with inputs state, roundKey and a lastRound flag.
REQ-034 AesRoundFun SHALL instantiate the existing SubBytes function block and implement ShiftRows, MixColumns (bypassed when lastRound=1) and AddRoundKey.
REQ-035 aes_round_ctrl SHALL contain the FSM, the round counter, stateReg and the handshakes, plus one AesRoundFun instance.

Verification
REQ-036 The bench SHALL model a key store that supplies FIPS-197 AES-256 round keys from roundIdx combinationally.
REQ-037 Test 1, vector: key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> outData 8ea2b7ca516745bfeafc49904b496089, with outValid 14 cycles after accept.
REQ-038 Test 2, backpressure: outReady=0 for 20 cycles after outValid -> outValid/outData stable and inReady=0 throughout; release -> IDLE next cycle.
REQ-039 Test 3, back-to-back: 3 blocks with inValid held high and outReady=1 -> 3 correct ciphertexts, with accepts spaced 16 cycles apart.
REQ-040 Test 4, reset mid-operation: rst asserted at rnd=7 -> IDLE, outData=0, no outValid; the next block (REQ-037 vector) SHALL still produce the correct result.
REQ-041 Test 5, ignored input: inValid toggled and inData randomised during ROUND -> result unchanged; roundIdx sequence 0,1..14 checked every cycle.
